mem_pair_xfer: RTL and testbench
================================

# mem_pair_xfer

Parametrised successor to the fixed 8x8 to 8x4 pairwise memory transfer datapath.

- Loads a source register-file of 2^SRC_ADDR_WIDTH words.
- On a Start pulse, walks the source memory in adjacent pairs and combines each pair through a mode-selectable add/subtract/compare unit.
- Writes one result per pair into a half-depth destination memory, which a host reads back.
- Adds a start/busy/done handshake, four combine modes, optional saturation and a sticky overflow flag.

## Interface

Parameters:
- DATA_WIDTH, 8, word width of source and destination memories
- SRC_ADDR_WIDTH, 3, source address width; minimum 1. Destination depth is 2^(SRC_ADDR_WIDTH-1).
- SATURATE, 0, 0 = results wrap modulo 2^DATA_WIDTH; 1 = results clamp

Ports:
- Clk  in  1  single clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- LoadEn  in  1  write LoadData to the source memory at the load pointer
- LoadData  in  DATA_WIDTH  source write data
- Start  in  1  begin a transfer run; single-cycle pulse
- Mode  in  2  combine mode; sampled on the accepted Start
- Busy  out  1  run in progress
- Done  out  1  one-cycle pulse at the end of a run
- Ovf  out  1  sticky: a result in the current/last run wrapped or clamped
- RdAddr  in  SRC_ADDR_WIDTH-1  destination read address
- RdData  out  DATA_WIDTH  combinational read of dst[RdAddr]

## Operation

- Operands: for pair k, a = src[2k] and b = src[2k+1]. Both are unsigned.
- Arithmetic is performed at DATA_WIDTH+1 bits; the result is then truncated or clamped.
- Modes:
  - 00 compare-select: if a > b, result = a+b; otherwise result = a−b.
  - 01: result = a+b always.
  - 10: result = a−b always.
  - 11: result = |a−b|.
- Overflow is raised when either:
  - an add carries out, or
  - a subtract borrows (b > a).
- Effect of overflow on the result:
  - SATURATE=0: the result is the low DATA_WIDTH bits.
  - SATURATE=1: add clamps to all-ones; subtract clamps to 0.
  - Mode 11 never overflows.
- Loading:
  - In IDLE, LoadEn writes src[ldptr] and increments ldptr, which wraps from max to 0.
  - LoadEn is ignored while Busy.
  - ldptr returns to 0 on Reset and on each Done.
- FSM states: IDLE, RD_A, RD_B, WR, FIN.
  - IDLE: Start → RD_A. Starting a run clears k, clears Ovf and latches Mode.
  - RD_A: latch a = src[2k] → RD_B.
  - RD_B: latch b = src[2k+1] → WR.
  - WR: write the result to dst[k] and OR the overflow into Ovf. If k is the last pair → FIN; otherwise k++ → RD_A.
  - FIN: Done=1 → IDLE.
- Start while not in IDLE is ignored.
- Start and LoadEn in the same IDLE cycle: Start is accepted and the load is dropped (ldptr unchanged).
- Source memory read is combinational; no read latency inside the FSM.

## Timing

- Reset values:
  - Busy=0, Done=0, Ovf=0.
  - State=IDLE, ldptr=0, k=0.
  - All destination words = 0, so RdData=0.
  - Source contents are not cleared.
- Busy=1 in RD_A, RD_B and WR; 0 in IDLE and FIN.
- Latency: with Start accepted at edge t, Done is high during cycle t+3·D+1, where D = destination depth. For default parameters (D=4), Done is high 13 cycles after Start.
- dst[k] is visible on RdData the cycle after its WR edge. Reading an address during its write cycle returns the old value.
- Ovf is valid from the WR edge of the offending pair and holds until the next accepted Start or Reset.
- Reset mid-run:
  - State returns to IDLE on that edge.
  - Destination is cleared and Done is not pulsed.
  - Partial results are discarded.
- Mode and LoadData changes during a run have no effect.

## Structure

- Package mem_xfer_pkg holds:
  - FSM state enum.
  - Mode encodings MODE_CMP, MODE_ADD, MODE_SUB, MODE_ABS.
- Sub-module pair_alu: purely combinational.
  - Inputs: a, b, mode, plus SATURATE as a parameter.
  - Outputs: result and ovf.
  - Contains the comparator, adder/subtractor, abs and saturation logic.
- Top level contains:
  - Source and destination register files.
  - ldptr and k counters.
  - FSM, operand latches and Ovf flag.

## Test plan

All scenarios use DATA_WIDTH=8 and SRC_ADDR_WIDTH=3.

- Reset, then read all 4 destination addresses → RdData=0, Busy=0, Done=0, Ovf=0.
- Load 10,3,2,7,50,50,200,100; Start with Mode=00, SATURATE=0:
  - Done exactly 13 cycles after Start.
  - Destination = 13, 251, 0, 44.
  - Ovf=1.
- Same data with SATURATE=1 and Mode=00 → destination = 13, 0, 0, 255; Ovf=1.
- Same data with Mode=11 → destination = 7, 5, 0, 100; Ovf=0.
- Robustness:
  - Start and LoadEn pulsed while Busy → ignored: result unchanged and ldptr unchanged.
  - Start and LoadEn in the same IDLE cycle → run starts and the load is dropped.
- Reset asserted during RD_B of pair 2 → IDLE next cycle, all destination words = 0, no Done pulse; a subsequent clean run completes normally.

Source files
------------

// File: rtl/mem_xfer_pkg.sv
// Shared types for the pairwise memory transfer datapath: FSM states and combine modes.
package mem_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_CMP = 2'b00,
    MODE_ADD = 2'b01,
    MODE_SUB = 2'b10,
    MODE_ABS = 2'b11
  } mode_e;

endpackage

// File: rtl/pair_alu.sv
// Combinational pair combiner: compare-select, add, subtract or absolute difference,
// with carry/borrow detection and optional clamping.
module pair_alu
  import mem_xfer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SATURATE   = 0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  mode_e                 mode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam bit          SAT = (SATURATE != 0);

  logic [W:0] sum_c;
  logic [W:0] diff_c;
  logic       a_gt_b_c;
  logic       do_add_c;

  assign sum_c    = {1'b0, a} + {1'b0, b};
  assign diff_c   = {1'b0, a} - {1'b0, b};
  assign a_gt_b_c = (a > b);

  // Select add vs subtract; compare-select adds only when a strictly exceeds b
  always_comb begin
    do_add_c = 1'b0;
    case (mode)
      MODE_CMP: do_add_c = a_gt_b_c;
      MODE_ADD: do_add_c = 1'b1;
      default:  do_add_c = 1'b0;
    endcase
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    if (mode == MODE_ABS) begin
      result = a_gt_b_c ? diff_c[W-1:0] : W'(b - a);
    end else if (do_add_c) begin
      ovf    = sum_c[W];
      result = (ovf && SAT) ? '1 : sum_c[W-1:0];
    end else begin
      ovf    = diff_c[W];
      result = (ovf && SAT) ? '0 : diff_c[W-1:0];
    end
  end

endmodule

// File: rtl/mem_pair_xfer.sv
// Loads a source register file, then on Start combines adjacent word pairs into a
// half-depth destination memory with a start/busy/done handshake and sticky overflow.
module mem_pair_xfer
  import mem_xfer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SRC_ADDR_WIDTH = 3,
  parameter int unsigned SATURATE       = 0
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      LoadEn,
  input  logic [DATA_WIDTH-1:0]     LoadData,
  input  logic                      Start,
  input  logic [1:0]                Mode,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Ovf,
  input  logic [SRC_ADDR_WIDTH-2:0] RdAddr,
  output logic [DATA_WIDTH-1:0]     RdData
);

  localparam int unsigned DW        = DATA_WIDTH;
  localparam int unsigned SAW       = SRC_ADDR_WIDTH;
  localparam int unsigned DAW       = SRC_ADDR_WIDTH - 1;
  localparam int unsigned SRC_DEPTH = 1 << SAW;
  localparam int unsigned DST_DEPTH = 1 << DAW;

  logic [DW-1:0]  src_q [SRC_DEPTH];
  logic [DW-1:0]  dst_q [DST_DEPTH];

  state_e         state_q, state_d;
  logic [SAW-1:0] ldptr_q, ldptr_d;
  logic [DAW-1:0] k_q, k_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  mode_e          mode_q, mode_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           src_we_c;
  logic           dst_we_c;
  logic [DW-1:0]  alu_result_c;
  logic           alu_ovf_c;

  pair_alu #(
    .DATA_WIDTH (DW),
    .SATURATE   (SATURATE)
  ) u_pair_alu (
    .a      (a_q),
    .b      (b_q),
    .mode   (mode_q),
    .result (alu_result_c),
    .ovf    (alu_ovf_c)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ldptr_q <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_CMP;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ldptr_q <= ldptr_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Source contents deliberately survive reset
  always_ff @(posedge Clk) begin
    if (src_we_c && !Reset) begin
      src_q[ldptr_q] <= LoadData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(DST_DEPTH); i++) begin
        dst_q[i] <= '0;
      end
    end else if (dst_we_c) begin
      dst_q[k_q] <= alu_result_c;
    end
  end

  always_comb begin
    state_d  = state_q;
    ldptr_d  = ldptr_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    src_we_c = 1'b0;
    dst_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Start has priority; a simultaneous load is dropped
        if (Start) begin
          state_d = ST_RD_A;
          k_d     = '0;
          ovf_d   = 1'b0;
          mode_d  = mode_e'(Mode);
        end else if (LoadEn) begin
          src_we_c = 1'b1;
          ldptr_d  = ldptr_q + SAW'(1);
        end
      end
      ST_RD_A: begin
        a_d     = src_q[{k_q, 1'b0}];
        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        b_d     = src_q[{k_q, 1'b1}];
        state_d = ST_WR;
      end
      ST_WR: begin
        dst_we_c = 1'b1;
        ovf_d    = ovf_q | alu_ovf_c;
        if (k_q == DAW'(DST_DEPTH - 1)) begin
          state_d = ST_FIN;
        end else begin
          k_d     = k_q + DAW'(1);
          state_d = ST_RD_A;
        end
      end
      ST_FIN: begin
        ldptr_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RD_A) || (state_d == ST_RD_B) || (state_d == ST_WR);
    done_d = (state_d == ST_FIN);
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Ovf    = ovf_q;
  assign RdData = dst_q[RdAddr];

endmodule

// File: tb/tb_mem_pair_xfer.sv
// Self-checking bench: wrapping and saturating instances share stimulus and are
// compared against an arithmetic reference model of the pairwise transfer.
module tb_mem_pair_xfer;

  logic       clk;
  logic       Reset;
  logic       LoadEn;
  logic [7:0] LoadData;
  logic       Start;
  logic [1:0] Mode;
  logic [1:0] RdAddr;
  logic       busy0, done0, ovf0;
  logic       busy1, done1, ovf1;
  logic [7:0] rd0, rd1;

  int errors = 0;
  int checks = 0;

  int src_m [8];
  int exp_w [4];
  int exp_s [4];
  bit ovf_m;
  int ldptr_m;

  mem_pair_xfer #(.DATA_WIDTH(8), .SRC_ADDR_WIDTH(3), .SATURATE(0)) u_wrap (
    .Clk(clk), .Reset(Reset), .LoadEn(LoadEn), .LoadData(LoadData), .Start(Start),
    .Mode(Mode), .Busy(busy0), .Done(done0), .Ovf(ovf0), .RdAddr(RdAddr), .RdData(rd0)
  );

  mem_pair_xfer #(.DATA_WIDTH(8), .SRC_ADDR_WIDTH(3), .SATURATE(1)) u_sat (
    .Clk(clk), .Reset(Reset), .LoadEn(LoadEn), .LoadData(LoadData), .Start(Start),
    .Mode(Mode), .Busy(busy1), .Done(done1), .Ovf(ovf1), .RdAddr(RdAddr), .RdData(rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: compute every destination word from the pair rules with integer math
  task automatic compute_model(input int mode);
    int a, b, r;
    bit add, o;
    ovf_m = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = src_m[2*k];
      b = src_m[2*k+1];
      if (mode == 3) begin
        r = (a > b) ? a - b : b - a;
        exp_w[k] = r;
        exp_s[k] = r;
      end else begin
        add = (mode == 1) || (mode == 0 && a > b);
        if (add) begin
          r = a + b;
          o = (r > 255);
          exp_w[k] = o ? r - 256 : r;
          exp_s[k] = o ? 255 : r;
        end else begin
          r = a - b;
          o = (r < 0);
          exp_w[k] = o ? r + 256 : r;
          exp_s[k] = o ? 0 : r;
        end
        ovf_m = ovf_m | o;
      end
    end
  endtask

  task automatic load_words(input int n, input bit rnd, input int v0, input int v1,
                            input int v2, input int v3, input int v4, input int v5,
                            input int v6, input int v7);
    int vals [8];
    vals = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      LoadEn   = 1'b1;
      LoadData = rnd ? 8'($urandom_range(0, 255)) : 8'(vals[i]);
      src_m[ldptr_m] = int'(LoadData);
      ldptr_m = (ldptr_m + 1) % 8;
    end
    @(negedge clk);
    LoadEn = 1'b0;
  endtask

  task automatic check_dst(input string tag);
    for (int a = 0; a < 4; a++) begin
      RdAddr = 2'(a);
      #1;
      checks++;
      if (rd0 !== 8'(exp_w[a])) begin
        errors++;
        $display("FAIL %s wrap dst[%0d]: got %0d expected %0d", tag, a, rd0, exp_w[a]);
      end
      checks++;
      if (rd1 !== 8'(exp_s[a])) begin
        errors++;
        $display("FAIL %s sat dst[%0d]: got %0d expected %0d", tag, a, rd1, exp_s[a]);
      end
    end
  endtask

  // Start a run, optionally poke Start/LoadEn mid-run, then check latency, flags and results
  task automatic run_and_check(input int mode, input bit inject, input bit load_with_start,
                               input string tag);
    int n;
    @(negedge clk);
    Start = 1'b1;
    Mode  = 2'(mode);
    if (load_with_start) begin
      LoadEn   = 1'b1;
      LoadData = 8'hAA;
    end
    @(negedge clk);
    Start  = 1'b0;
    LoadEn = 1'b0;
    Mode   = 2'($urandom_range(0, 3));
    n = 1;
    while (!done0 && n < 60) begin
      if (n == 3) begin
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
          errors++;
          $display("FAIL %s busy mid-run: got %b/%b expected 1", tag, busy0, busy1);
        end
      end
      if (inject && n == 5) begin
        Start    = 1'b1;
        LoadEn   = 1'b1;
        LoadData = 8'($urandom_range(0, 255));
        Mode     = 2'(3 - mode);
      end
      @(negedge clk);
      Start  = 1'b0;
      LoadEn = 1'b0;
      n++;
    end
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b1 || n != 13) begin
      errors++;
      $display("FAIL %s done latency: got %0d cycles (done %b/%b) expected 13", tag, n, done0, done1);
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL %s busy at done: got %b/%b expected 0", tag, busy0, busy1);
    end
    compute_model(mode);
    ldptr_m = 0;
    checks++;
    if (ovf0 !== ovf_m || ovf1 !== ovf_m) begin
      errors++;
      $display("FAIL %s ovf: got %b/%b expected %b", tag, ovf0, ovf1, ovf_m);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse width: got %b/%b expected 0", tag, done0, done1);
    end
    check_dst(tag);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    ldptr_m = 0;
    for (int k = 0; k < 4; k++) begin
      exp_w[k] = 0;
      exp_s[k] = 0;
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got busy=%b%b done=%b%b ovf=%b%b expected all 0",
               busy0, busy1, done0, done1, ovf0, ovf1);
    end
    check_dst("reset");
  endtask

  task automatic test_directed();
    load_words(8, 1'b0, 10, 3, 2, 7, 50, 50, 200, 100);
    run_and_check(0, 1'b0, 1'b0, "cmp");
    run_and_check(3, 1'b0, 1'b0, "abs");
    run_and_check(1, 1'b0, 1'b0, "add");
    run_and_check(2, 1'b0, 1'b0, "sub");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      load_words(8, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      run_and_check(int'($urandom_range(0, 3)), 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_busy_ignore();
    load_words(8, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_and_check(0, 1'b1, 1'b0, "busy_ignore");
    // Partial load then rerun confirms ldptr restarted at 0 after the run
    load_words(3, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_and_check(1, 1'b0, 1'b0, "ldptr_after_run");
  endtask

  task automatic test_start_with_load();
    load_words(5, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_and_check(2, 1'b0, 1'b1, "start_load_same");
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit saw_done;
    load_words(8, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    Start = 1'b1;
    Mode  = 2'd1;
    @(negedge clk);
    Start = 1'b0;
    for (n = 1; n < 8; n++) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset busy before reset: got %b expected 1", busy0);
    end
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
        ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset flags: got busy=%b%b done=%b%b ovf=%b%b expected all 0",
               busy0, busy1, done0, done1, ovf0, ovf1);
    end
    for (int k = 0; k < 4; k++) begin
      exp_w[k] = 0;
      exp_s[k] = 0;
    end
    ldptr_m = 0;
    check_dst("mid_reset");
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || done1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_reset done pulse: got 1 expected 0");
    end
    run_and_check(1, 1'b0, 1'b0, "after_mid_reset");
  endtask

  initial begin
    Reset    = 1'b1;
    LoadEn   = 1'b0;
    LoadData = '0;
    Start    = 1'b0;
    Mode     = '0;
    RdAddr   = '0;
    for (int i = 0; i < 8; i++) src_m[i] = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_start_with_load();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
